bdb_button_debouncer: RTL and testbench
=======================================

# bdb_button_debouncer

Synthesizable front end of the debounced-counter design. It synchronizes the raw push-button input, filters contact bounce with a stability counter and a four-state FSM, and produces `pressPulse`, a one-clock strobe per accepted press. The bench responder consumes `pressPulse`, and an on-chip running press count feeds the display logic. Release events are also filtered, so one physical press yields exactly one pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles of stable level required to accept a press or a release. Legal range is ≥2.
- `COUNT_WIDTH`, default 8: width of `pressCount`.
- `BUTTON_ACTIVE_LOW`, default 1: when 1, raw `button` = 0 means pressed.
- `clock`, input, 1: sole clock; all state is on its rising edge.
- `reset`, input, 1: asynchronous, active-low. Asserting it (0) clears all state immediately. Release is sampled on `clock`.
- `button`, input, 1: raw, asynchronous, bouncing button level.
- `countClear`, input, 1: synchronous clear of `pressCount`.
- `pressPulse`, output, 1: high for exactly one cycle per accepted press.
- `releasePulse`, output, 1: high for exactly one cycle per accepted release.
- `pressed`, output, 1: debounced level. High in PRESSED and RELEASE_WAIT.
- `pressCount`, output, `COUNT_WIDTH`: number of accepted presses, modulo 2^`COUNT_WIDTH`.

## Operation
- **Input normalization**: `button` is XOR'd with `BUTTON_ACTIVE_LOW` to give an active-high level. That level passes through a two-flop synchronizer to give `btn_s`. The synchronizer flops reset to "not pressed".
- **Stability counter**: `stab_cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide. It is cleared on every state entry and increments in the WAIT states.
- **IDLE**
  - `btn_s`=1: go to PRESS_WAIT, `stab_cnt`=0.
- **PRESS_WAIT**
  - `btn_s`=0: return to IDLE. No pulse.
  - `btn_s`=1 and `stab_cnt`==`DEBOUNCE_CYCLES`-1: go to PRESSED, register `pressPulse`=1, increment `pressCount`.
  - Otherwise: increment `stab_cnt`.
- **PRESSED**
  - `btn_s`=0: go to RELEASE_WAIT, `stab_cnt`=0.
- **RELEASE_WAIT**
  - `btn_s`=1: return to PRESSED. No pulse, no count.
  - `btn_s`=0 and `stab_cnt`==`DEBOUNCE_CYCLES`-1: go to IDLE, register `releasePulse`=1.
  - Otherwise: increment `stab_cnt`.
- **Counter arithmetic**: `pressCount` wraps from 2^`COUNT_WIDTH`-1 to 0 with no flag.
- **Clear and press in the same cycle**: if `countClear` coincides with an accepted press, `pressCount` becomes 1 (clear first, then count).
- **Reset mid-operation**: asserting `reset` in any state forces IDLE. All outputs return to 0 asynchronously. A press in progress is discarded, with no pulse before or after reset.
- **Button held through reset release**: re-qualified from IDLE. One pulse after the full latency.

## Timing
- **Reset values**: `pressPulse`=0, `releasePulse`=0, `pressed`=0, `pressCount`=0, state=IDLE, `stab_cnt`=0, synchronizer flops "not pressed".
- **Registered outputs**: all outputs are registered. There is no combinational path from `button` or `countClear` to any output.
- **Press latency**: raw press first sampled at edge k, then held stable. `btn_s` rises at edge k+1. PRESS_WAIT is entered at edge k+2. PRESSED is entered and `pressPulse` rises at edge k+2+`DEBOUNCE_CYCLES`, falling at the next edge.
- **Release latency**: symmetric. `releasePulse` rises at edge k+2+`DEBOUNCE_CYCLES` after the raw release is first sampled at edge k.
- **`pressed` timing**: `pressed` changes on the same edge that `pressPulse` or `releasePulse` rises.
- **Pulse spacing**: consecutive `pressPulse` strobes are at least 2·`DEBOUNCE_CYCLES`+2 cycles apart.
- **`countClear` timing**: takes effect at the edge on which it is sampled high.

## Structure
- **Package `bdb_pkg`**:
  - `typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} bdb_state_t`.
  - Localparam helper for the `stab_cnt` width.
- **Sub-module `bdb_synchronizer`**: two-flop synchronizer, parameterized by reset value, with the same `clock`/`reset` as the parent. It is reused by later input stages.
- **Top module**: FSM, stability counter and press counter live in `bdb_button_debouncer`. Implementation is roughly 150–250 lines.

## Test plan
- **Clean press**: `DEBOUNCE_CYCLES`=4, active-high, `button` rises at edge 10 and is held 20 cycles. Expect `pressPulse` high only between edges 16 and 17, `pressCount`=1, and `pressed`=1 from edge 16.
- **Bounce rejection**: `button` toggles 1,0,1,0 on consecutive edges, then is held 1. Expect exactly one `pressPulse`, at 2+`DEBOUNCE_CYCLES` edges after the final rise is sampled.
- **Release glitch**: while PRESSED, `button` drops for 2 cycles (< `DEBOUNCE_CYCLES`). Expect no `releasePulse`, no second `pressPulse`, `pressCount` unchanged, and `pressed` staying 1.
- **Wraparound and clear**: `COUNT_WIDTH`=2, 4 clean presses. Expect `pressCount` 1,2,3,0. Then assert `countClear` on the cycle of a 5th accepted press; expect `pressCount`=1.
- **Reset mid-qualification**: assert `reset` while in PRESS_WAIT with `stab_cnt`=2, release 3 cycles later with `button` still held. Expect outputs 0 immediately, no pulse during reset, and one `pressPulse` 2+`DEBOUNCE_CYCLES` edges after the first post-reset sample.
- **Active-low polarity**: `BUTTON_ACTIVE_LOW`=1, idle `button`=1 with no events. Driving `button`=0 and holding it produces a `pressPulse` at the standard latency.

Source files
------------

// File: rtl/bdb_pkg.sv
//------------------------------------------------------------------------------
// Module   : bdb_pkg
// Purpose  : Shared types and helpers for the button debouncer front end.
//            - bdb_state_t   : debouncer FSM state encoding
//            - bdb_cnt_width : width of the stability counter for a given
//                              debounce length
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bdb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } bdb_state_t;

  // Stability counter must hold DEBOUNCE_CYCLES-1; never narrower than 1 bit.
  function automatic int bdb_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage : bdb_pkg

`default_nettype wire

// File: rtl/bdb_synchronizer.sv
//------------------------------------------------------------------------------
// Module   : bdb_synchronizer
// Purpose  : Two-flop synchronizer for a single asynchronous level.
// Ports    : clock - sampling clock (rising edge)
//            reset - asynchronous active-low reset, loads RESET_VALUE
//            d     - asynchronous input level
//            q     - synchronized level (two clock stages of latency)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bdb_synchronizer #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : bdb_synchronizer

`default_nettype wire

// File: rtl/bdb_button_debouncer.sv
//------------------------------------------------------------------------------
// Module   : bdb_button_debouncer
// Purpose  : Synchronizes a raw bouncing push-button, qualifies presses and
//            releases with a stability counter, and emits one-cycle strobes
//            plus a running press count.
// Ports    : clock        - sole clock, rising edge
//            reset        - asynchronous active-low reset
//            button       - raw asynchronous button level
//            countClear   - synchronous clear of pressCount
//            pressPulse   - one-cycle strobe per accepted press
//            releasePulse - one-cycle strobe per accepted release
//            pressed      - debounced level
//            pressCount   - accepted presses modulo 2^COUNT_WIDTH
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bdb_button_debouncer
  import bdb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,  // legal range >= 2
  parameter int COUNT_WIDTH       = 8,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button,
  input  logic                   countClear,
  output logic                   pressPulse,
  output logic                   releasePulse,
  output logic                   pressed,
  output logic [COUNT_WIDTH-1:0] pressCount
);

  localparam int                     STAB_W     = bdb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0]      STAB_LAST  = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAB_W-1:0]      STAB_ONE   = STAB_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  // Normalize to active-high before synchronizing so the synchronizer's
  // reset value of 0 always means "not pressed".
  logic w_btn_level;
  logic btn_s;

  assign w_btn_level = button ^ BUTTON_ACTIVE_LOW;

  bdb_synchronizer #(
    .RESET_VALUE (1'b0)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (w_btn_level),
    .q     (btn_s)
  );

  bdb_state_t                state_d, state_q;
  logic [STAB_W-1:0]         stab_cnt_d, stab_cnt_q;
  logic                      press_pulse_d, press_pulse_q;
  logic                      release_pulse_d, release_pulse_q;
  logic                      pressed_d, pressed_q;
  logic [COUNT_WIDTH-1:0]    press_count_d, press_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      stab_cnt_q      <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      pressed_q       <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      stab_cnt_q      <= stab_cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      pressed_q       <= pressed_d;
      press_count_q   <= press_count_d;
    end
  end

  // Next-state logic. The stability counter is zeroed on every transition so
  // each WAIT state starts counting from a clean 0.
  always_comb begin
    state_d         = state_q;
    stab_cnt_d      = stab_cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d    = PRESS_WAIT;
          stab_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d    = IDLE;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d       = PRESSED;
          stab_cnt_d    = '0;
          press_pulse_d = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_d    = RELEASE_WAIT;
          stab_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d    = PRESSED;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d         = IDLE;
          stab_cnt_d      = '0;
          release_pulse_d = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end

      default: begin
        state_d    = IDLE;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Registered debounced level tracks the next state so it moves on the same
  // edge as the corresponding strobe.
  always_comb begin
    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // Clear takes priority, then an accepted press counts on top of it, so a
  // coincident clear and press leaves the count at 1.
  always_comb begin
    press_count_d = countClear ? '0 : press_count_q;
    if (press_pulse_d) begin
      press_count_d = press_count_d + COUNT_ONE;
    end
  end

  assign pressPulse   = press_pulse_q;
  assign releasePulse = release_pulse_q;
  assign pressed      = pressed_q;
  assign pressCount   = press_count_q;

endmodule : bdb_button_debouncer

`default_nettype wire

// File: tb/tb_bdb_button_debouncer.sv
//------------------------------------------------------------------------------
// Module   : tb_bdb_button_debouncer
// Purpose  : Self-checking bench for bdb_button_debouncer. Instance A is
//            active-high with a 2-bit count; instance B is active-low.
//            Expected strobes are queued when stimulus is driven and compared
//            against strobes captured by the monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bdb_button_debouncer;

  localparam int D = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_n;
  logic       btn_a, clr_a, pp_a, rp_a, pr_a;
  logic [1:0] cnt_a;
  logic       btn_b, clr_b, pp_b, rp_b, pr_b;
  logic [7:0] cnt_b;

  bdb_button_debouncer #(
    .DEBOUNCE_CYCLES   (D),
    .COUNT_WIDTH       (2),
    .BUTTON_ACTIVE_LOW (1'b0)
  ) dut_a (
    .clock        (clock),
    .reset        (rst_n),
    .button       (btn_a),
    .countClear   (clr_a),
    .pressPulse   (pp_a),
    .releasePulse (rp_a),
    .pressed      (pr_a),
    .pressCount   (cnt_a)
  );

  bdb_button_debouncer #(
    .DEBOUNCE_CYCLES   (D),
    .COUNT_WIDTH       (8),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut_b (
    .clock        (clock),
    .reset        (rst_n),
    .button       (btn_b),
    .countClear   (clr_b),
    .pressPulse   (pp_b),
    .releasePulse (rp_b),
    .pressed      (pr_b),
    .pressCount   (cnt_b)
  );

  typedef struct packed {
    int ev_edge;
    int ev_cnt;
  } ev_t;

  int  edge_cnt = 0;
  int  npass    = 0;
  int  ntotal   = 0;
  ev_t pa_obs[$], pa_exp[$], pb_obs[$], pb_exp[$];
  int  ra_obs[$], ra_exp[$], rb_obs[$], rb_exp[$];

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Capture every strobe with the edge number it rose on.
  always @(negedge clock) begin
    if (pp_a === 1'b1) pa_obs.push_back('{ev_edge: edge_cnt, ev_cnt: int'(cnt_a)});
    if (rp_a === 1'b1) ra_obs.push_back(edge_cnt);
    if (pp_b === 1'b1) pb_obs.push_back('{ev_edge: edge_cnt, ev_cnt: int'(cnt_b)});
    if (rp_b === 1'b1) rb_obs.push_back(edge_cnt);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_a = 1'b0; clr_a = 1'b0;
    btn_b = 1'b1; clr_b = 1'b0;
    tick(3);
    ntotal++;
    if ({pp_a, rp_a, pr_a, cnt_a} !== 5'b0)
      $display("FAIL reset_a: got %b want 00000", {pp_a, rp_a, pr_a, cnt_a});
    else npass++;
    ntotal++;
    if ({pp_b, rp_b, pr_b, cnt_b} !== 11'b0)
      $display("FAIL reset_b: got %b want 0", {pp_b, rp_b, pr_b, cnt_b});
    else npass++;
    rst_n = 1'b1;
    tick(10);
    ntotal++;
    if (pa_obs.size() + ra_obs.size() + pb_obs.size() + rb_obs.size() != 0)
      $display("FAIL reset_idle_strobes: got %0d want 0",
               pa_obs.size() + ra_obs.size() + pb_obs.size() + rb_obs.size());
    else npass++;
    ntotal++;
    if (pr_a !== 1'b0) $display("FAIL reset_idle_pressed: got %b want 0", pr_a);
    else npass++;
  endtask

  task automatic test_clean_press();
    int  pexp;
    ev_t o, e;
    int  ro, re;
    btn_a = 1'b1;
    pexp  = edge_cnt + 3 + D;
    pa_exp.push_back('{ev_edge: pexp, ev_cnt: 1});
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (edge_cnt == pexp - 1) begin
        ntotal++;
        if (pr_a !== 1'b0) $display("FAIL clean_pressed_early: got %b want 0", pr_a);
        else npass++;
      end
      if (edge_cnt == pexp) begin
        ntotal++;
        if (pr_a !== 1'b1) $display("FAIL clean_pressed_rise: got %b want 1", pr_a);
        else npass++;
      end
      if (edge_cnt == pexp + 1) begin
        ntotal++;
        if (pp_a !== 1'b0) $display("FAIL clean_pulse_fall: got %b want 0", pp_a);
        else npass++;
      end
    end
    btn_a = 1'b0;
    ra_exp.push_back(edge_cnt + 3 + D);
    tick(D + 8);
    ntotal++;
    if (pr_a !== 1'b0) $display("FAIL clean_released_level: got %b want 0", pr_a);
    else npass++;
    ntotal++;
    if (cnt_a !== 2'd1) $display("FAIL clean_count: got %0d want 1", cnt_a);
    else npass++;
    ntotal++;
    if (pa_obs.size() != pa_exp.size())
      $display("FAIL clean_npress: got %0d want %0d", pa_obs.size(), pa_exp.size());
    else npass++;
    while (pa_obs.size() > 0 && pa_exp.size() > 0) begin
      o = pa_obs.pop_front(); e = pa_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL clean_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL clean_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    ntotal++;
    if (ra_obs.size() != ra_exp.size())
      $display("FAIL clean_nrelease: got %0d want %0d", ra_obs.size(), ra_exp.size());
    else npass++;
    while (ra_obs.size() > 0 && ra_exp.size() > 0) begin
      ro = ra_obs.pop_front(); re = ra_exp.pop_front();
      ntotal++;
      if (ro !== re) $display("FAIL clean_release_edge: got %0d want %0d", ro, re);
      else npass++;
    end
    pa_obs.delete(); pa_exp.delete(); ra_obs.delete(); ra_exp.delete();
  endtask

  task automatic test_bounce();
    ev_t o, e;
    int  ro, re;
    btn_a = 1'b1; tick(1);
    btn_a = 1'b0; tick(1);
    btn_a = 1'b1; tick(1);
    btn_a = 1'b0; tick(1);
    btn_a = 1'b1;
    pa_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: 2});
    tick(D + 8);
    ntotal++;
    if (pr_a !== 1'b1) $display("FAIL bounce_pressed: got %b want 1", pr_a);
    else npass++;
    btn_a = 1'b0;
    ra_exp.push_back(edge_cnt + 3 + D);
    tick(D + 8);
    ntotal++;
    if (pa_obs.size() != pa_exp.size())
      $display("FAIL bounce_npress: got %0d want %0d", pa_obs.size(), pa_exp.size());
    else npass++;
    while (pa_obs.size() > 0 && pa_exp.size() > 0) begin
      o = pa_obs.pop_front(); e = pa_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL bounce_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL bounce_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    ntotal++;
    if (ra_obs.size() != ra_exp.size())
      $display("FAIL bounce_nrelease: got %0d want %0d", ra_obs.size(), ra_exp.size());
    else npass++;
    while (ra_obs.size() > 0 && ra_exp.size() > 0) begin
      ro = ra_obs.pop_front(); re = ra_exp.pop_front();
      ntotal++;
      if (ro !== re) $display("FAIL bounce_release_edge: got %0d want %0d", ro, re);
      else npass++;
    end
    pa_obs.delete(); pa_exp.delete(); ra_obs.delete(); ra_exp.delete();
  endtask

  task automatic test_release_glitch();
    ev_t o, e;
    int  ro, re;
    int  drops;
    btn_a = 1'b1;
    pa_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: 3});
    tick(D + 6);
    btn_a = 1'b0; tick(2);
    btn_a = 1'b1;
    drops = 0;
    for (int i = 0; i < D + 8; i++) begin
      tick(1);
      if (pr_a !== 1'b1) drops++;
    end
    ntotal++;
    if (drops != 0) $display("FAIL glitch_pressed_drops: got %0d want 0", drops);
    else npass++;
    ntotal++;
    if (ra_obs.size() != 0) $display("FAIL glitch_release_pulse: got %0d want 0", ra_obs.size());
    else npass++;
    ntotal++;
    if (cnt_a !== 2'd3) $display("FAIL glitch_count: got %0d want 3", cnt_a);
    else npass++;
    ntotal++;
    if (pa_obs.size() != pa_exp.size())
      $display("FAIL glitch_npress: got %0d want %0d", pa_obs.size(), pa_exp.size());
    else npass++;
    while (pa_obs.size() > 0 && pa_exp.size() > 0) begin
      o = pa_obs.pop_front(); e = pa_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL glitch_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL glitch_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    btn_a = 1'b0;
    ra_exp.push_back(edge_cnt + 3 + D);
    tick(D + 8);
    ntotal++;
    if (ra_obs.size() != ra_exp.size())
      $display("FAIL glitch_nrelease: got %0d want %0d", ra_obs.size(), ra_exp.size());
    else npass++;
    while (ra_obs.size() > 0 && ra_exp.size() > 0) begin
      ro = ra_obs.pop_front(); re = ra_exp.pop_front();
      ntotal++;
      if (ro !== re) $display("FAIL glitch_release_edge: got %0d want %0d", ro, re);
      else npass++;
    end
    pa_obs.delete(); pa_exp.delete(); ra_obs.delete(); ra_exp.delete();
  endtask

  task automatic test_wrap_clear();
    ev_t o, e;
    int  mcount;
    bit  clr_on;
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(2);
    mcount = 0;
    for (int i = 0; i < 7; i++) begin
      clr_on = (i == 4) || (i == 6);
      mcount = clr_on ? 1 : (mcount + 1) % 4;
      btn_a = 1'b1;
      pa_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: mcount});
      tick(D + 2);
      clr_a = clr_on;
      tick(1);
      clr_a = 1'b0;
      tick(4);
      btn_a = 1'b0;
      tick(D + 6);
    end
    clr_a = 1'b1; tick(1);
    clr_a = 1'b0; tick(1);
    ntotal++;
    if (cnt_a !== 2'd0) $display("FAIL wrap_plain_clear: got %0d want 0", cnt_a);
    else npass++;
    ntotal++;
    if (pa_obs.size() != pa_exp.size())
      $display("FAIL wrap_npress: got %0d want %0d", pa_obs.size(), pa_exp.size());
    else npass++;
    while (pa_obs.size() > 0 && pa_exp.size() > 0) begin
      o = pa_obs.pop_front(); e = pa_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL wrap_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL wrap_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    ntotal++;
    if (ra_obs.size() != 7) $display("FAIL wrap_nrelease: got %0d want 7", ra_obs.size());
    else npass++;
    pa_obs.delete(); pa_exp.delete(); ra_obs.delete(); ra_exp.delete();
  endtask

  task automatic test_reset_mid();
    ev_t o, e;
    // One press so the count is non-zero before the reset hits.
    btn_a = 1'b1;
    pa_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: 1});
    tick(D + 6);
    btn_a = 1'b0;
    tick(D + 6);
    // Raw press; after 5 edges the FSM sits in PRESS_WAIT with stab_cnt = 2.
    btn_a = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    ntotal++;
    if ({pp_a, rp_a, pr_a, cnt_a} !== 5'b0)
      $display("FAIL midreset_async_clear: got %b want 00000", {pp_a, rp_a, pr_a, cnt_a});
    else npass++;
    tick(3);
    rst_n = 1'b1;
    pa_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: 1});
    tick(D + 8);
    ntotal++;
    if (pa_obs.size() != pa_exp.size())
      $display("FAIL midreset_npress: got %0d want %0d", pa_obs.size(), pa_exp.size());
    else npass++;
    while (pa_obs.size() > 0 && pa_exp.size() > 0) begin
      o = pa_obs.pop_front(); e = pa_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL midreset_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL midreset_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    btn_a = 1'b0;
    tick(D + 8);
    pa_obs.delete(); pa_exp.delete(); ra_obs.delete(); ra_exp.delete();
  endtask

  task automatic test_active_low();
    ev_t o, e;
    int  ro, re;
    ntotal++;
    if (pb_obs.size() + rb_obs.size() != 0)
      $display("FAIL actlow_idle_strobes: got %0d want 0", pb_obs.size() + rb_obs.size());
    else npass++;
    btn_b = 1'b0;
    pb_exp.push_back('{ev_edge: edge_cnt + 3 + D, ev_cnt: 1});
    tick(D + 6);
    ntotal++;
    if (pr_b !== 1'b1) $display("FAIL actlow_pressed: got %b want 1", pr_b);
    else npass++;
    btn_b = 1'b1;
    rb_exp.push_back(edge_cnt + 3 + D);
    tick(D + 6);
    ntotal++;
    if (pb_obs.size() != pb_exp.size())
      $display("FAIL actlow_npress: got %0d want %0d", pb_obs.size(), pb_exp.size());
    else npass++;
    while (pb_obs.size() > 0 && pb_exp.size() > 0) begin
      o = pb_obs.pop_front(); e = pb_exp.pop_front();
      ntotal++;
      if (o.ev_edge !== e.ev_edge) $display("FAIL actlow_press_edge: got %0d want %0d", o.ev_edge, e.ev_edge);
      else npass++;
      ntotal++;
      if (o.ev_cnt !== e.ev_cnt) $display("FAIL actlow_press_cnt: got %0d want %0d", o.ev_cnt, e.ev_cnt);
      else npass++;
    end
    ntotal++;
    if (rb_obs.size() != rb_exp.size())
      $display("FAIL actlow_nrelease: got %0d want %0d", rb_obs.size(), rb_exp.size());
    else npass++;
    while (rb_obs.size() > 0 && rb_exp.size() > 0) begin
      ro = rb_obs.pop_front(); re = rb_exp.pop_front();
      ntotal++;
      if (ro !== re) $display("FAIL actlow_release_edge: got %0d want %0d", ro, re);
      else npass++;
    end
    pb_obs.delete(); pb_exp.delete(); rb_obs.delete(); rb_exp.delete();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_wrap_clear();
    test_reset_mid();
    test_active_low();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule : tb_bdb_button_debouncer

`default_nettype wire
